// File: rtl/ws2812_pkg.sv
// Shared types and helpers for the multi-lane WS2812 serialiser.
// Holds the FSM state encoding, the colour-order codes and the wire-order reorder function.
package ws2812_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_LATCH
  } state_t;

  localparam logic ORDER_GRB = 1'b0;
  localparam logic ORDER_RGB = 1'b1;

  // Frame-buffer words are {R,G,B}; GRB strings expect green on the wire first.
  function automatic logic [23:0] wire_order(input logic [23:0] rgb, input logic order);
    return (order == ORDER_RGB) ? rgb : {rgb[15:8], rgb[23:16], rgb[7:0]};
  endfunction

endpackage

// File: rtl/ws2812_lane.sv
// One output string: pending pixel register, 24-bit shift word and registered dout.
// All timing decisions come from the shared strobes driven by the top.
module ws2812_lane
  import ws2812_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        order,
  input  logic [23:0] rgb,
  input  logic        capture,
  input  logic        load,
  input  logic        reload,
  input  logic        shift,
  input  logic        bit_phase_high,
  input  logic        bit_phase_long,
  output logic        dout
);

  logic [23:0] word;
  logic [23:0] pending;
  logic [23:0] shift_reg;
  logic [23:0] shift_next;

  assign word = wire_order(rgb, order);

  always_comb begin
    shift_next = shift_reg;
    if (load)
      shift_next = word;
    else if (reload)
      shift_next = pending;
    else if (shift)
      shift_next = {shift_reg[22:0], 1'b0};
  end

  // dout looks at the bit that will be current in the next cycle, so pixel
  // and bit boundaries switch without a gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      shift_reg <= '0;
      dout      <= 1'b0;
    end else begin
      if (capture)
        pending <= word;
      shift_reg <= shift_next;
      dout      <= bit_phase_high | (bit_phase_long & shift_next[23]);
    end
  end

endmodule

// File: rtl/ws2812_multi_driver.sv
// Multi-lane WS2812 serialiser fed from a synchronous-read frame buffer.
// The FSM and shared bit/cycle/pixel counters live here; per-lane data lives in ws2812_lane.
module ws2812_multi_driver
  import ws2812_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int LED_COUNT = 64,
  parameter int ADDR_W    = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1,
  parameter int T_BIT     = 63,
  parameter int T0H       = 20,
  parameter int T1H       = 40,
  parameter int T_RESET   = 14000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     order,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [CHANNELS*24-1:0]   rd_data,
  output logic [CHANNELS-1:0]      dout,
  output logic                     busy,
  output logic                     done
);

  localparam int CW = $clog2(T_BIT);
  localparam int LW = $clog2(T_RESET + 1);

  state_t              state;
  logic                order_reg;
  logic [CW-1:0]       cyc_cnt;
  logic [4:0]          bit_cnt;
  logic [ADDR_W-1:0]   pix_cnt;
  logic [LW-1:0]       lat_cnt;

  logic          end_bit, last_bit, last_pix;
  logic          load_s, shift_s, reload_s, capture_s, active_next;
  logic          phase_high, phase_long;
  logic [CW-1:0] cyc_next;

  always_comb begin
    end_bit     = (int'(cyc_cnt) == T_BIT - 1);
    last_bit    = (bit_cnt == 5'd23);
    last_pix    = (int'(pix_cnt) == LED_COUNT - 1);
    load_s      = (state == S_LOAD);
    shift_s     = (state == S_SHIFT) && end_bit && !last_bit;
    reload_s    = (state == S_SHIFT) && end_bit && last_bit && !last_pix;
    // Prefetched word is on rd_data during cycle 1 of bit 0.
    capture_s   = (state == S_SHIFT) && (bit_cnt == 5'd0) && (int'(cyc_cnt) == 1);
    active_next = load_s || ((state == S_SHIFT) && !(end_bit && last_bit && last_pix));
    cyc_next    = (load_s || end_bit) ? '0 : cyc_cnt + CW'(1);
    phase_high  = active_next && (int'(cyc_next) < T0H);
    phase_long  = active_next && (int'(cyc_next) < T1H);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      order_reg <= ORDER_GRB;
      cyc_cnt   <= '0;
      bit_cnt   <= '0;
      pix_cnt   <= '0;
      lat_cnt   <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            order_reg <= order;
            busy      <= 1'b1;
            rd_en     <= 1'b1;
            rd_addr   <= '0;
            pix_cnt   <= '0;
            bit_cnt   <= '0;
            state     <= S_FETCH;
          end
        end
        S_FETCH: state <= S_LOAD;
        S_LOAD: begin
          cyc_cnt <= cyc_next;
          state   <= S_SHIFT;
          if (LED_COUNT > 1) begin
            rd_en   <= 1'b1;
            rd_addr <= ADDR_W'(1);
          end
        end
        S_SHIFT: begin
          cyc_cnt <= cyc_next;
          if (end_bit) begin
            if (!last_bit) begin
              bit_cnt <= bit_cnt + 5'd1;
            end else if (last_pix) begin
              lat_cnt <= '0;
              state   <= S_LATCH;
            end else begin
              bit_cnt <= '0;
              pix_cnt <= pix_cnt + ADDR_W'(1);
              if (int'(pix_cnt) + 2 < LED_COUNT) begin
                rd_en   <= 1'b1;
                rd_addr <= pix_cnt + ADDR_W'(2);
              end
            end
          end
        end
        S_LATCH: begin
          if (int'(lat_cnt) == T_RESET - 1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
      ws2812_lane u_lane (
        .clk            (clk),
        .reset          (reset),
        .order          (order_reg),
        .rgb            (rd_data[gi*24 +: 24]),
        .capture        (capture_s),
        .load           (load_s),
        .reload         (reload_s),
        .shift          (shift_s),
        .bit_phase_high (phase_high),
        .bit_phase_long (phase_long),
        .dout           (dout[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_ws2812_multi_driver.sv
// Bench for ws2812_multi_driver: BRAM model, pulse-decoding receiver per lane and a
// scoreboard of expected wire words and read addresses pushed when each frame begins.
module tb_ws2812_multi_driver;

  localparam int CH = 2;
  localparam int L  = 3;
  localparam int AW = 2;
  localparam int TB = 10;
  localparam int T0 = 3;
  localparam int T1 = 6;
  localparam int TR = 20;
  localparam int FRAME_BUSY = 2 + L * 24 * TB + TR;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              order = 1'b0;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [CH*24-1:0]  rd_data = '0;
  logic [CH-1:0]     dout;
  logic              busy;
  logic              done;

  ws2812_multi_driver #(
    .CHANNELS (CH), .LED_COUNT (L), .T_BIT (TB),
    .T0H (T0), .T1H (T1), .T_RESET (TR)
  ) dut (
    .clk (clk), .reset (reset), .start (start), .order (order),
    .rd_en (rd_en), .rd_addr (rd_addr), .rd_data (rd_data),
    .dout (dout), .busy (busy), .done (done)
  );

  always #5 clk = ~clk;

  logic [CH*24-1:0] mem [L];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // What a GRB string expects on the wire: green, red, blue; RGB strings take the word as is.
  function automatic logic [23:0] wire_word(input logic [23:0] rgb, input logic ord);
    logic [7:0] r, g, b;
    r = rgb[23:16]; g = rgb[15:8]; b = rgb[7:0];
    return ord ? {r, g, b} : {g, r, b};
  endfunction

  logic [23:0] exp_q [CH][$];
  int          addr_q [$];
  logic        prev_busy = 1'b0;
  int          busy_run = 0, idle_run = 0, done_cnt = 0;
  bit          expect_gap1 = 1'b0;
  int          run_len [CH];
  int          since_rise [CH];
  int          nbits [CH];
  logic [23:0] shreg [CH];
  logic        prev_d [CH];

  // Monitor / receiver: decodes pulses into words and pops the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      prev_busy = 1'b0; busy_run = 0; idle_run = 0;
      addr_q.delete();
      for (int c = 0; c < CH; c++) begin
        exp_q[c].delete();
        run_len[c] = 0; since_rise[c] = 100000; nbits[c] = 0;
        shreg[c] = '0; prev_d[c] = 1'b0;
      end
    end else begin
      if (busy && !prev_busy) begin
        if (expect_gap1) check("idle_gap", idle_run, 1);
        for (int p = 0; p < L; p++) begin
          addr_q.push_back(p);
          for (int c = 0; c < CH; c++) exp_q[c].push_back(wire_word(mem[p][c*24 +: 24], order));
        end
        busy_run = 0;
      end
      if (!busy && prev_busy) idle_run = 0;
      if (busy) busy_run++; else idle_run++;
      check("done", longint'(done), longint'(prev_busy && !busy));
      if (prev_busy && !busy) begin
        check("busy_len", busy_run, FRAME_BUSY);
        check("rd_en_missing", addr_q.size(), 0);
        for (int c = 0; c < CH; c++) check($sformatf("lane%0d_words_left", c), exp_q[c].size(), 0);
      end
      if (done) done_cnt++;
      if (rd_en) begin
        if (addr_q.size() == 0) check("rd_en_extra", 1, 0);
        else check("rd_addr", longint'(rd_addr), addr_q.pop_front());
      end
      if (!busy) check("dout_idle", longint'(dout), 0);
      for (int c = 0; c < CH; c++) begin
        if (since_rise[c] < 100000) since_rise[c]++;
        if (dout[c] && !prev_d[c]) begin
          if (since_rise[c] < TB + TR) check($sformatf("lane%0d_period", c), since_rise[c], TB);
          since_rise[c] = 0;
          run_len[c] = 1;
        end else if (dout[c]) begin
          run_len[c]++;
        end else if (prev_d[c]) begin
          check($sformatf("lane%0d_pulse_len", c), run_len[c], (run_len[c] > (T0 + T1) / 2) ? T1 : T0);
          shreg[c] = {shreg[c][22:0], run_len[c] > (T0 + T1) / 2};
          nbits[c]++;
          if (nbits[c] == 24) begin
            nbits[c] = 0;
            if (exp_q[c].size() == 0) check($sformatf("lane%0d_word_extra", c), longint'(shreg[c]), 0);
            else check($sformatf("lane%0d_word", c), longint'(shreg[c]), longint'(exp_q[c].pop_front()));
            $display("lane%0d word %06h", c, shreg[c]);
          end
        end
        prev_d[c] = dout[c];
      end
      prev_busy = busy;
    end
  end

  task automatic randomize_mem();
    for (int p = 0; p < L; p++) mem[p] = {24'($urandom), 24'($urandom)};
  endtask

  task automatic run_frame(input logic ord, input bit spam);
    int  d0;
    bit  got;
    d0 = done_cnt;
    got = 1'b0;
    @(negedge clk); order = ord; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < FRAME_BUSY + 50 && !got; i++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; start = 1'b0; end
      else start = spam && ($urandom_range(0, 5) == 0);
    end
    start = 1'b0;
    if (!got) check("frame_timeout", 0, 1);
    repeat (4) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    $display("frame order=%0d spam=%0d complete", ord, spam);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int frames;
    randomize_mem();
    repeat (3) @(negedge clk);
    check("reset_state", longint'({dout, busy, done, rd_en, rd_addr}), 0);
    reset = 1'b0;

    mem[0] = {24'($urandom), 24'hFF0000};
    mem[1] = {24'($urandom), 24'h00FF00};
    mem[2] = {24'($urandom), 24'h0000AA};
    run_frame(1'b0, 1'b0);
    run_frame(1'b1, 1'b0);

    randomize_mem();
    run_frame(1'($urandom_range(0, 1)), 1'b1);

    // Abort mid-bit in pixel 1, then a full frame must follow from address 0.
    randomize_mem();
    @(negedge clk); order = 1'($urandom_range(0, 1)); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2 + 24 * TB + 55) @(posedge clk);
    #2 reset = 1'b1;
    #1 check("reset_async", longint'({dout, busy, done, rd_en, rd_addr}), 0);
    @(negedge clk);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(negedge clk);
    run_frame(1'($urandom_range(0, 1)), 1'b0);

    // start held high: frames separated by one idle cycle after done.
    randomize_mem();
    @(negedge clk); order = 1'($urandom_range(0, 1)); start = 1'b1;
    frames = 0;
    for (int i = 0; i < 4 * FRAME_BUSY && frames < 3; i++) begin
      @(negedge clk);
      if (i == 10 && busy) expect_gap1 = 1'b1;
      if (done) begin
        frames++;
        if (frames == 3) start = 1'b0;
      end
    end
    start = 1'b0;
    check("held_frames", frames, 3);
    repeat (4) @(negedge clk);
    expect_gap1 = 1'b0;
    $display("held-start frames complete: %0d", frames);

    for (int f = 0; f < 4; f++) begin
      randomize_mem();
      run_frame(1'($urandom_range(0, 1)), f[0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ws2812_multi_driver.md
# ws2812_multi_driver

Parametrised multi-lane WS2812/WS2812B serialiser: drives `CHANNELS` LED strings in lockstep, `LED_COUNT` pixels each, fetching pixel words from a synchronous-read frame buffer instead of a flat input bus. Bit timing and latch time are parameters in clock cycles, and wire colour order is selectable per frame. The block sits between the frame-buffer BRAM and the FPGA output pins, and replaces the single-string, flat-bus driver for large hologram arrays.

## Interface
- `CHANNELS`, 4: number of independent output strings (≥1)
- `LED_COUNT`, 64: pixels per string (≥1)
- `ADDR_W`, `$clog2(LED_COUNT)` (min 1): pixel address width
- `T_BIT`, 63: cycles per bit (1.26 µs at 50 MHz)
- `T0H`, 20: high cycles for a 0 bit
- `T1H`, 40: high cycles for a 1 bit; legality is 0 < T0H < T1H < T_BIT
- `T_RESET`, 14000: low latch cycles after a frame (280 µs)
- `clk` in 1: system clock, 50 MHz
- `reset` in 1: asynchronous, active-high reset
- `start` in 1: frame request; a single-cycle pulse suffices
- `order` in 1: colour order, sampled with `start`; 0 = GRB on wire, 1 = RGB on wire
- `rd_en` out 1: frame-buffer read strobe
- `rd_addr` out ADDR_W: pixel index
- `rd_data` in CHANNELS*24: lane c occupies `[c*24 +: 24]` as {R,G,B}; valid on the cycle after `rd_en`
- `dout` out CHANNELS: serial line per lane
- `busy` out 1: frame in progress
- `done` out 1: one-cycle pulse at end of latch

## Operation
- States: IDLE → FETCH → LOAD → SHIFT → LATCH → IDLE.
- IDLE: `start`=1 at a posedge latches `order` and moves to FETCH. `start` is ignored in all other states, with no queuing.
- FETCH (1 cycle): `rd_en`=1, `rd_addr`=0.
- LOAD (1 cycle): capture `rd_data` and reorder each lane into its shift word. GRB sends G[7:0], R, B, MSB first; RGB sends R, G, B.
- SHIFT: one bit period is `T_BIT` cycles. `dout[c]`=1 for the first T1H cycles if the lane's current bit is 1, else for the first T0H cycles; low for the remainder of the period. All lanes share one bit counter and one cycle counter.
- Prefetch: on the first cycle of bit 0 of pixel k (k < LED_COUNT−1), assert `rd_en` with `rd_addr`=k+1. Capture the result into a pending register on the next cycle. At the end of bit 23, load the pending register into the shift word. There is no gap between pixels.
- After bit 23 of pixel LED_COUNT−1, enter LATCH: all `dout` low for exactly T_RESET cycles, then go to IDLE with `done`=1 for that one cycle.
- `rd_en` is asserted exactly LED_COUNT times per frame. `rd_addr` holds its last value when `rd_en`=0.
- Reset (any state, asynchronous): state=IDLE; `dout`=0, `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0; all counters and shift words are cleared. A partially sent frame is abandoned. The next `start` begins again at pixel 0.

## Timing
- Start accepted at edge E0. `busy`=1 from E0+1. FETCH occupies E0→E0+1 and LOAD occupies E0+1→E0+2. The first `dout` rising edge is at E0+2.
- SHIFT length is LED_COUNT·24·T_BIT cycles. The first bit of pixel k starts at E0+2+k·24·T_BIT.
- `busy` stays high through LATCH. `busy` falls on the same edge at which `done` rises. Total busy time is 2 + LED_COUNT·24·T_BIT + T_RESET cycles.
- A `start` held high across the `done` cycle is accepted in IDLE on the following edge. Back-to-back frames therefore carry one idle cycle.
- `dout` is registered (glitch-free) and is 0 at all times outside SHIFT.

## Structure
- Package `ws2812_pkg`:
  - state enum
  - `ORDER_GRB`/`ORDER_RGB` constants
  - a function that reorders a 24-bit {R,G,B} word to wire order
- Sub-module `ws2812_lane`, instantiated CHANNELS times. It contains the pending register, the 24-bit shift word and the `dout` register, and takes `load`, `shift`, `bit_phase_high` strobes from the top.
- The top holds the FSM, the cycle/bit/pixel counters and the read interface.

## Test plan
- Run with CHANNELS=2, LED_COUNT=3, T_BIT=10, T0H=3, T1H=6, T_RESET=20, ORDER=GRB and a BRAM model. Lane0 holds pixels {FF0000, 00FF00, 0000AA}. The decoding receiver must return 00FF00, FF0000, 0000AA in wire order. Every high pulse is 3 or 6 cycles, and every period is 10 cycles.
- Run the same data with `order`=1. The receiver must return FF0000, 00FF00, 0000AA, with lane1 independent and checked against its own data.
- Pulse `start` for one cycle. Check `busy` from E0+1 to E0+2+720+20, a single `done` pulse, exactly 3 `rd_en` pulses at addresses 0, 1, 2, and no idle gap between pixels.
- Pulse `start` repeatedly during a frame. The frame must be unaffected and exactly one `done` pulse must occur.
- Assert `reset` mid-bit in pixel 1. All outputs must be 0 within the same cycle. A new `start` must restart at `rd_addr`=0 with a correct full frame.
- Hold `start` high continuously. Consecutive frames must be separated by T_RESET low cycles plus one idle cycle.
